cobro_pago: RTL and testbench

- Payment responder on the far end of the payment-menu FSM's request lines.
- Consumes the menu's cash request (EFE) or card request (TAR), collects coins or waits for the card terminal, and dispenses change one coin per cycle.
- Reports the outcome back to the menu/display side with one-cycle OK or failure pulses.
- Sits between the menu controller, the coin acceptor/dispenser hardware and the card terminal.

---
 rtl/cobro_pago.sv | 163 ++++++++++++++++
 tb/tb_cobro_pago.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cobro_pago.sv
// cobro_pago: payment responder for the payment-menu FSM.
// Takes a cash (EFE) or card (TAR) request, collects coins or waits for the
// card terminal, pays back change one coin per cycle and reports the outcome
// to the menu with a one-cycle PAGO_OK / PAGO_NO pulse. All outputs are registered.
module cobro_pago #(
    parameter int W     = 8,
    parameter int T_TAR = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         EFE,
    input  logic         TAR,
    input  logic [W-1:0] PRECIO,
    input  logic         M1,
    input  logic         M5,
    input  logic         M10,
    input  logic         TOK,
    input  logic         TRECH,
    input  logic         CLC,
    output logic         OCUP,
    output logic [W:0]   CRED,
    output logic         D1,
    output logic         D5,
    output logic         D10,
    output logic         PAGO_OK,
    output logic         PAGO_NO
);

    typedef enum logic [2:0] {
        IDLE,
        COBRO,
        TARJ,
        VUELTO,
        LISTO
    } state_t;

    localparam logic [W:0] CRED_MAX = '1;
    localparam logic [W:0] ONE      = (W+1)'(1);
    localparam logic [W:0] FIVE     = (W+1)'(5);
    localparam logic [W:0] TEN      = (W+1)'(10);
    localparam logic [7:0] TIMEOUT  = 8'(T_TAR);

    state_t       state;
    logic [W-1:0] precio_q;
    logic [W:0]   change;
    logic [7:0]   timer;
    logic         fail;
    logic [W:0]   cred_next;
    logic [W:0]   precio_ext;

    // Adds this cycle's coins to the credit, clamping at the register maximum
    // so a long stream of coins can never wrap the credit back to a small value.
    function automatic logic [W:0] sat_add(input logic [W:0] a, input logic m1,
                                           input logic m5, input logic m10);
        logic [W+2:0] s;
        s = {2'b00, a} + (W+3)'(m1)
            + (m5  ? (W+3)'(5)  : '0)
            + (m10 ? (W+3)'(10) : '0);
        sat_add = (s > {2'b00, CRED_MAX}) ? CRED_MAX : s[W:0];
    endfunction

    assign cred_next  = sat_add(CRED, M1, M5, M10);
    assign precio_ext = {1'b0, precio_q};

    // Single controller: state, credit, change, card timer and every registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            CRED    <= '0;
            change  <= '0;
            timer   <= '0;
            fail    <= 1'b0;
            OCUP    <= 1'b0;
            D1      <= 1'b0;
            D5      <= 1'b0;
            D10     <= 1'b0;
            PAGO_OK <= 1'b0;
            PAGO_NO <= 1'b0;
        end else begin
            // Dispense and result lines are pulses: low unless set below.
            D1      <= 1'b0;
            D5      <= 1'b0;
            D10     <= 1'b0;
            PAGO_OK <= 1'b0;
            PAGO_NO <= 1'b0;
            case (state)
                IDLE: begin
                    if (EFE) begin
                        precio_q <= PRECIO;
                        CRED     <= '0;
                        OCUP     <= 1'b1;
                        state    <= COBRO;
                    end else if (TAR) begin
                        precio_q <= PRECIO;
                        timer    <= '0;
                        OCUP     <= 1'b1;
                        state    <= TARJ;
                    end
                end
                COBRO: begin
                    if (CLC) begin
                        // Cancel refunds what was already in; coins arriving
                        // on the cancel cycle are not counted.
                        change <= CRED;
                        fail   <= 1'b1;
                        state  <= VUELTO;
                    end else begin
                        CRED <= cred_next;
                        if (cred_next >= precio_ext) begin
                            change <= cred_next - precio_ext;
                            fail   <= 1'b0;
                            state  <= VUELTO;
                        end
                    end
                end
                TARJ: begin
                    timer <= timer + 8'd1;
                    if (CLC || TRECH) begin
                        fail    <= 1'b1;
                        PAGO_NO <= 1'b1;
                        state   <= LISTO;
                    end else if (TOK) begin
                        fail    <= 1'b0;
                        PAGO_OK <= 1'b1;
                        state   <= LISTO;
                    end else if (timer == TIMEOUT) begin
                        fail    <= 1'b1;
                        PAGO_NO <= 1'b1;
                        state   <= LISTO;
                    end
                end
                VUELTO: begin
                    // Largest coin first; the result pulse is raised on the
                    // edge that enters LISTO so it is visible during LISTO.
                    if (change >= TEN) begin
                        D10    <= 1'b1;
                        change <= change - TEN;
                    end else if (change >= FIVE) begin
                        D5     <= 1'b1;
                        change <= change - FIVE;
                    end else if (change >= ONE) begin
                        D1     <= 1'b1;
                        change <= change - ONE;
                    end else begin
                        PAGO_OK <= ~fail;
                        PAGO_NO <= fail;
                        state   <= LISTO;
                    end
                end
                LISTO: begin
                    CRED  <= '0;
                    OCUP  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    OCUP  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cobro_pago.sv
// tb_cobro_pago: directed vectors for cobro_pago with a pulse scoreboard.
// Stimulus pushes the expected D10/D5/D1/PAGO_OK/PAGO_NO pulse sequence; a
// monitor pops one entry for every cycle in which any pulse output is high.
module tb_cobro_pago;

    localparam int W     = 8;
    localparam int T_TAR = 16;

    localparam logic [4:0] EV_D10 = 5'b10000;
    localparam logic [4:0] EV_D5  = 5'b01000;
    localparam logic [4:0] EV_D1  = 5'b00100;
    localparam logic [4:0] EV_OK  = 5'b00010;
    localparam logic [4:0] EV_NO  = 5'b00001;

    logic         clk = 1'b0;
    logic         reset;
    logic         EFE, TAR, M1, M5, M10, TOK, TRECH, CLC;
    logic [W-1:0] PRECIO;
    logic         OCUP, D1, D5, D10, PAGO_OK, PAGO_NO;
    logic [W:0]   CRED;

    int         nvec = 0;
    int         nerr = 0;
    logic [4:0] expq[$];
    bit         mon_en = 1'b0;

    cobro_pago #(.W(W), .T_TAR(T_TAR)) dut (
        .clk(clk), .reset(reset), .EFE(EFE), .TAR(TAR), .PRECIO(PRECIO),
        .M1(M1), .M5(M5), .M10(M10), .TOK(TOK), .TRECH(TRECH), .CLC(CLC),
        .OCUP(OCUP), .CRED(CRED), .D1(D1), .D5(D5), .D10(D10),
        .PAGO_OK(PAGO_OK), .PAGO_NO(PAGO_NO)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor: every cycle with a pulse must match the next queued event.
    always @(negedge clk) begin
        logic [4:0] v;
        logic [4:0] e;
        v = {D10, D5, D1, PAGO_OK, PAGO_NO};
        if (mon_en && v != 5'b0) begin
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_pulse: got %b, expected no pulse", v);
            end else begin
                e = expq.pop_front();
                chk("pulse_seq", int'(v), int'(e));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input logic e, input logic t, input logic [W-1:0] p,
                       input logic m1, input logic m5, input logic m10,
                       input logic tok, input logic trech, input logic clc);
        EFE = e; TAR = t; PRECIO = p;
        M1 = m1; M5 = m5; M10 = m10;
        TOK = tok; TRECH = trech; CLC = clc;
        @(negedge clk);
        EFE = 0; TAR = 0; M1 = 0; M5 = 0; M10 = 0;
        TOK = 0; TRECH = 0; CLC = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (OCUP && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(OCUP), 0);
    endtask

    initial begin
        int lat;
        bit seen;
        reset = 1'b0;
        EFE = 0; TAR = 0; PRECIO = '0; M1 = 0; M5 = 0; M10 = 0;
        TOK = 0; TRECH = 0; CLC = 0;
        idle(2);
        chk("reset_ocup", int'(OCUP), 0);
        chk("reset_cred", int'(CRED), 0);
        chk("reset_pulses", int'({D10, D5, D1, PAGO_OK, PAGO_NO}), 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Coins, card and cancel in IDLE are ignored.
        cyc(0, 0, 8'd9, 1, 1, 1, 1, 1, 1);
        chk("idle_ignore_cred", int'(CRED), 0);
        chk("idle_ignore_ocup", int'(OCUP), 0);

        // Price 25, three 10-unit coins: change 5.
        expq.push_back(EV_D5); expq.push_back(EV_OK);
        cyc(1, 0, 8'd25, 0, 0, 0, 0, 0, 0);
        chk("p25_ocup", int'(OCUP), 1);
        chk("p25_cred0", int'(CRED), 0);
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 0, 0);
        chk("p25_cred10", int'(CRED), 10);
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 0, 0);
        chk("p25_cred20", int'(CRED), 20);
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 0, 0);
        chk("p25_cred30", int'(CRED), 30);
        wait_idle("p25_done", 20);
        chk("p25_cred_clear", int'(CRED), 0);

        // Price 7, all three coins together: credit 16, change 9 = 5+1+1+1+1.
        expq.push_back(EV_D5); expq.push_back(EV_D1); expq.push_back(EV_D1);
        expq.push_back(EV_D1); expq.push_back(EV_D1); expq.push_back(EV_OK);
        cyc(1, 0, 8'd7, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 8'd0, 1, 1, 1, 0, 0, 0);
        chk("p7_cred16", int'(CRED), 16);
        wait_idle("p7_done", 20);
        chk("p7_cred_clear", int'(CRED), 0);

        // Price 50, 10 + 5, then cancel with a 1-unit coin: refund 15.
        expq.push_back(EV_D10); expq.push_back(EV_D5); expq.push_back(EV_NO);
        cyc(1, 0, 8'd50, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 8'd0, 0, 1, 0, 0, 0, 0);
        chk("cancel_cred15", int'(CRED), 15);
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 0, 1);
        chk("cancel_m1_ignored", int'(CRED), 15);
        wait_idle("cancel_done", 20);

        // Price 0 completes on the first COBRO cycle with no change.
        expq.push_back(EV_OK);
        cyc(1, 0, 8'd0, 0, 0, 0, 0, 0, 0);
        wait_idle("p0_done", 10);

        // Card approved: PAGO_OK one clock after TOK.
        expq.push_back(EV_OK);
        cyc(0, 1, 8'd40, 0, 0, 0, 0, 0, 0);
        chk("card_ocup", int'(OCUP), 1);
        idle(1);
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 0, 0);
        chk("card_ok_latency", int'(PAGO_OK), 1);
        wait_idle("card_ok_done", 5);

        // TOK and TRECH together on the 3rd card cycle: rejection wins.
        expq.push_back(EV_NO);
        cyc(0, 1, 8'd40, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 1, 0);
        chk("tok_trech_no", int'(PAGO_NO), 1);
        chk("tok_trech_not_ok", int'(PAGO_OK), 0);
        wait_idle("tok_trech_done", 5);

        // Card timeout with no response.
        expq.push_back(EV_NO);
        cyc(0, 1, 8'd40, 0, 0, 0, 0, 0, 0);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (PAGO_NO) seen = 1'b1;
        end
        nvec++;
        if (!(seen && lat >= 17 && lat <= 18)) begin
            nerr++;
            $display("FAIL tar_timeout_latency: got %0d cycles (seen=%0d), expected 17..18", lat, seen);
        end
        wait_idle("timeout_done", 5);

        // EFE and TAR together: cash path, TOK ignored, price 3 paid with a 5.
        cyc(1, 1, 8'd3, 0, 0, 0, 0, 0, 0);
        chk("efe_tar_ocup", int'(OCUP), 1);
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 0, 0);
        chk("efe_tar_tok_ignored", int'(OCUP), 1);
        expq.push_back(EV_D1); expq.push_back(EV_D1); expq.push_back(EV_OK);
        cyc(0, 0, 8'd0, 0, 1, 0, 0, 0, 0);
        chk("efe_tar_cred5", int'(CRED), 5);
        wait_idle("efe_tar_done", 20);

        // Reset held low two cycles mid-COBRO with credit 15.
        cyc(1, 0, 8'd100, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 8'd0, 0, 1, 1, 0, 0, 0);
        chk("midreset_cred15", int'(CRED), 15);
        reset = 1'b0;
        idle(2);
        chk("midreset_cred", int'(CRED), 0);
        chk("midreset_ocup", int'(OCUP), 0);
        reset = 1'b1;
        idle(3);
        chk("midreset_stays_idle", int'(OCUP), 0);

        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
